frame_deserializer: RTL

FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

---
 rtl/frame_deserializer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/frame_deserializer.sv
// Oversampled serial frame receiver: start bit, 5..DATA_WIDTH data bits, optional parity, stop bit.
// Produces a right-aligned word with a one-cycle valid pulse, plus sticky parity/stop error flags.
module frame_deserializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int LEN_WIDTH    = 4,
    parameter int EDGE_WIDTH   = 5,
    parameter int SCALER_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    des_en,
    input  logic                    start,
    input  logic                    sampled_bit,
    input  logic [EDGE_WIDTH-1:0]   edge_count,
    input  logic [SCALER_WIDTH-1:0] prescale,
    input  logic [LEN_WIDTH-1:0]    data_len,
    input  logic                    par_en,
    input  logic                    par_type,
    input  logic                    msb_first,
    output logic [DATA_WIDTH-1:0]   p_data,
    output logic                    data_valid,
    output logic                    par_err,
    output logic                    stp_err,
    output logic                    busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    // IDLE: wait for start | START: check start bit | DATA: collect bits | PARITY | STOP
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_q;
    logic [CW-1:0]             len_q;
    logic [CW-1:0]             cnt_q;
    logic                      par_en_q;
    logic                      par_type_q;
    logic                      msb_q;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic [DATA_WIDTH-1:0]     p_data_q;
    logic                      data_valid_q;
    logic                      par_err_q;
    logic                      stp_err_q;

    logic [SCALER_WIDTH-1:0]   strobe_pt;
    logic                      strobe;
    logic [CW-1:0]             bit_idx;
    logic                      last_bit;

    function automatic logic [CW-1:0] clamp_len(input logic [LEN_WIDTH-1:0] l);
        if (int'(l) < 5)
            return CW'(5);
        else if (int'(l) > DATA_WIDTH)
            return CW'(DATA_WIDTH);
        else
            return CW'(l);
    endfunction

    // Sample point sits just past mid-bit; the add wraps at SCALER_WIDTH bits.
    assign strobe_pt = (prescale >> 1) + SCALER_WIDTH'(2);
    assign strobe    = des_en && (SCALER_WIDTH'(edge_count) == strobe_pt);
    assign bit_idx   = msb_q ? (len_q - cnt_q - CW'(1)) : cnt_q;
    assign last_bit  = (cnt_q == len_q - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= CW'(5);
            cnt_q        <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            msb_q        <= 1'b0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            if (state_q != IDLE && !des_en) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && des_en) begin
                            state_q    <= START;
                            len_q      <= clamp_len(data_len);
                            par_en_q   <= par_en;
                            par_type_q <= par_type;
                            msb_q      <= msb_first;
                            cnt_q      <= '0;
                            shift_q    <= '0;
                            par_err_q  <= 1'b0;
                            stp_err_q  <= 1'b0;
                        end
                    end
                    START: begin
                        if (strobe)
                            state_q <= sampled_bit ? IDLE : DATA;
                    end
                    DATA: begin
                        if (strobe) begin
                            for (int i = 0; i < DATA_WIDTH; i++) begin
                                if (CW'(i) == bit_idx)
                                    shift_q[i] <= sampled_bit;
                            end
                            cnt_q <= cnt_q + CW'(1);
                            if (last_bit)
                                state_q <= par_en_q ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        if (strobe) begin
                            par_err_q <= sampled_bit != ((^shift_q) ^ par_type_q);
                            state_q   <= STOP;
                        end
                    end
                    STOP: begin
                        if (strobe) begin
                            stp_err_q <= ~sampled_bit;
                            if (sampled_bit && !par_err_q) begin
                                p_data_q     <= shift_q;
                                data_valid_q <= 1'b1;
                            end
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = (state_q != IDLE);

endmodule
